// File: rtl/tybec_stream_pkg.sv
// Shared types and defaults for the kernel input-stream source.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tybec_stream_pkg;

  localparam int STREAMW_DEF = 34;
  localparam int CNTW_DEF    = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/coriolis_stream_skid_fifo.sv
// Small per-lane skid FIFO between a memory-side stream and one kernel lane.
// Latency: word pushed at cycle t is visible on head_dat_o/head_vld_o at t+1.
// Backpressure: push_rdy_o drops when full at cycle start; no full-bypass on pop.
// Ports: clk/rst (async active-high); push_vld_i/push_rdy_o/push_dat_i write side;
//        pop_i removes the head; head_vld_o/head_dat_o present the registered head.
module coriolis_stream_skid_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld_i,
  output logic         push_rdy_o,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic         head_vld_o,
  output logic [W-1:0] head_dat_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          push, pop;

  // Fullness is judged on the occupancy at cycle start, so a same-cycle pop
  // never opens room for a push in that cycle.
  assign push_rdy_o = (cnt_q != FULL_CNT);
  assign push       = push_vld_i & push_rdy_o;
  assign pop        = pop_i & head_vld_o;

  assign head_vld_o = (cnt_q != '0);
  assign head_dat_o = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_dat_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/coriolis_stream_source.sv
// Producer for the coriolis kernel: merges x and un memory streams into aligned kernel lanes.
// Latency: mem word accepted at t appears on x_s0/un_s0 at t+1; 1 pair/cycle sustained.
// Backpressure: both lanes pop only together on iready; mem_*_ready drops on a full lane FIFO.
// Ports: clk/rst (async active-high); start/nwords run control; busy/done status;
//        mem_{x,un}_{data,valid,ready} memory side; {x,un}_s0/ivalid_{x,un}_s0/iready kernel side.
module coriolis_stream_source
  import tybec_stream_pkg::*;
#(
  parameter int STREAMW = STREAMW_DEF,
  parameter int CNTW    = CNTW_DEF,
  parameter int FIFOD   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNTW-1:0]    nwords,
  output logic               busy,
  output logic               done,
  input  logic [STREAMW-1:0] mem_x_data,
  input  logic               mem_x_valid,
  output logic               mem_x_ready,
  input  logic [STREAMW-1:0] mem_un_data,
  input  logic               mem_un_valid,
  output logic               mem_un_ready,
  output logic [STREAMW-1:0] x_s0,
  output logic               ivalid_x_s0,
  output logic [STREAMW-1:0] un_s0,
  output logic               ivalid_un_s0,
  input  logic               iready
);

  state_e          state_q;
  logic [CNTW-1:0] n_q;
  logic [CNTW-1:0] fx_q, fx_d;
  logic [CNTW-1:0] fu_q, fu_d;
  logic [CNTW-1:0] iss_q, iss_d;
  logic            busy_q, done_q;
  logic            x_rdy, u_rdy;
  logic            push_x, push_u, fire;

  // Each lane fetches independently, but stops at exactly N words.
  assign mem_x_ready  = (state_q == S_RUN) && x_rdy && (fx_q != n_q);
  assign mem_un_ready = (state_q == S_RUN) && u_rdy && (fu_q != n_q);
  assign push_x       = mem_x_valid & mem_x_ready;
  assign push_u       = mem_un_valid & mem_un_ready;

  // The kernel ANDs the lane valids, so a pair moves only when both heads are
  // present; popping one lane alone would misalign x and un for good.
  assign fire = ivalid_x_s0 & ivalid_un_s0 & iready;

  assign fx_d  = fx_q + CNTW'(push_x);
  assign fu_d  = fu_q + CNTW'(push_u);
  assign iss_d = iss_q + CNTW'(fire);

  assign busy = busy_q;
  assign done = done_q;

  coriolis_stream_skid_fifo #(
    .W     (STREAMW),
    .DEPTH (FIFOD)
  ) u_fifo_x (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (push_x),
    .push_rdy_o (x_rdy),
    .push_dat_i (mem_x_data),
    .pop_i      (fire),
    .head_vld_o (ivalid_x_s0),
    .head_dat_o (x_s0)
  );

  coriolis_stream_skid_fifo #(
    .W     (STREAMW),
    .DEPTH (FIFOD)
  ) u_fifo_un (
    .clk        (clk),
    .rst        (rst),
    .push_vld_i (push_u),
    .push_rdy_o (u_rdy),
    .push_dat_i (mem_un_data),
    .pop_i      (fire),
    .head_vld_o (ivalid_un_s0),
    .head_dat_o (un_s0)
  );

  // Transitions look at next-state counts so done lands the cycle right after
  // the final pair fire, with busy dropping in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      fx_q    <= '0;
      fu_q    <= '0;
      iss_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fx_q  <= fx_d;
      fu_q  <= fu_d;
      iss_q <= iss_d;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            n_q   <= nwords;
            fx_q  <= '0;
            fu_q  <= '0;
            iss_q <= '0;
            if (nwords == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (fx_d == n_q && fu_d == n_q) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (iss_d == n_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coriolis_stream_source.sv
module tb_coriolis_stream_source;
  localparam int SW = 34;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] nwords = '0;
  logic          busy, done;
  logic [SW-1:0] mem_x_data = '0;
  logic          mem_x_valid = 1'b0;
  logic          mem_x_ready;
  logic [SW-1:0] mem_un_data = '0;
  logic          mem_un_valid = 1'b0;
  logic          mem_un_ready;
  logic [SW-1:0] x_s0, un_s0;
  logic          ivalid_x_s0, ivalid_un_s0;
  logic          iready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  coriolis_stream_source #(.STREAMW(SW), .CNTW(CW), .FIFOD(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .nwords       (nwords),
    .busy         (busy),
    .done         (done),
    .mem_x_data   (mem_x_data),
    .mem_x_valid  (mem_x_valid),
    .mem_x_ready  (mem_x_ready),
    .mem_un_data  (mem_un_data),
    .mem_un_valid (mem_un_valid),
    .mem_un_ready (mem_un_ready),
    .x_s0         (x_s0),
    .ivalid_x_s0  (ivalid_x_s0),
    .un_s0        (un_s0),
    .ivalid_un_s0 (ivalid_un_s0),
    .iready       (iready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: observes the interface mid-cycle and keeps monotonic tallies.
  logic [SW-1:0] fx_log[$];
  logic [SW-1:0] fu_log[$];
  int  done_cnt = 0, busy_cnt = 0, xrdy_cnt = 0, urdy_cnt = 0, ival_cnt = 0;
  int  acc_x_cnt = 0, acc_u_cnt = 0, unstable_cnt = 0, xstall_cnt = 0, hold_cnt = 0;
  bit  acc_x = 0, acc_u = 0, hold_x = 0, hold_u = 0, fire_now = 0;
  logic [SW-1:0] last_x = '0, last_u = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_x = 0; hold_u = 0; acc_x = 0; acc_u = 0;
    end else begin
      fire_now = ivalid_x_s0 && ivalid_un_s0 && iready;
      if (hold_x && (!ivalid_x_s0 || x_s0 !== last_x)) unstable_cnt++;
      if (hold_u && (!ivalid_un_s0 || un_s0 !== last_u)) unstable_cnt++;
      hold_x = ivalid_x_s0 && !fire_now;
      hold_u = ivalid_un_s0 && !fire_now;
      last_x = x_s0;
      last_u = un_s0;
      if (fire_now) begin
        fx_log.push_back(x_s0);
        fu_log.push_back(un_s0);
      end
      if ((ivalid_x_s0 || ivalid_un_s0) && !fire_now) hold_cnt++;
      if (busy && mem_x_valid && !mem_x_ready && ivalid_x_s0 && !ivalid_un_s0) xstall_cnt++;
      done_cnt += int'(done);
      busy_cnt += int'(busy);
      xrdy_cnt += int'(mem_x_ready);
      urdy_cnt += int'(mem_un_ready);
      ival_cnt += int'(ivalid_x_s0 || ivalid_un_s0);
      acc_x = mem_x_valid && mem_x_ready;
      acc_u = mem_un_valid && mem_un_ready;
      acc_x_cnt += int'(acc_x);
      acc_u_cnt += int'(acc_u);
    end
  end

  // Pulses start, then feeds both memory lanes until done (or abort / timeout).
  task automatic drive_run(input int n, input int un_every, input int ir_mode,
                           input int xb, input int ub, input int max_cyc,
                           input int abort_fires, input int mid_start,
                           output int cyc, output bit timed_out);
    int xi = 0;
    int ui = 0;
    int base_f = fx_log.size();
    @(posedge clk); #1;
    nwords = CW'(n);
    start  = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    cyc       = 0;
    timed_out = 0;
    if (!done) begin
      while (1'b1) begin
        if (cyc == mid_start) begin
          start  = 1'b1;
          nwords = CW'(99);
        end else begin
          start = 1'b0;
        end
        mem_x_valid  = 1'b1;
        mem_x_data   = SW'(xb + xi + 1);
        mem_un_valid = (cyc % un_every == 0);
        mem_un_data  = SW'(ub + ui + 1);
        iready       = (ir_mode == 1) ? (cyc % 3 == 0) : 1'b1;
        @(posedge clk); #1;
        if (acc_x) xi++;
        if (acc_u) ui++;
        cyc++;
        if (done) break;
        if (abort_fires > 0 && fx_log.size() - base_f >= abort_fires) break;
        if (cyc >= max_cyc) begin
          timed_out = 1;
          break;
        end
      end
    end
    start        = 1'b0;
    mem_x_valid  = 1'b0;
    mem_un_valid = 1'b0;
    iready       = 1'b1;
    if (abort_fires == 0) begin
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (mem_x_ready !== 1'b0 || mem_un_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_mem_ready: got %b%b want 00", mem_x_ready, mem_un_ready); end
    n_checks++; if (ivalid_x_s0 !== 1'b0 || ivalid_un_s0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_ivalid: got %b%b want 00", ivalid_x_s0, ivalid_un_s0); end
    n_checks++; if (x_s0 !== '0 || un_s0 !== '0) begin
      n_fail++; $display("FAIL reset_data: got %0h/%0h want 0/0", x_s0, un_s0); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int cyc; bit to;
    int bf = fx_log.size(), bd = done_cnt, bb = busy_cnt, bax = acc_x_cnt, bau = acc_u_cnt, bun = unstable_cnt;
    drive_run(4, 1, 0, 0, 100, 60, 0, -1, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", to); end
    n_checks++; if (fx_log.size() - bf !== 4) begin n_fail++; $display("FAIL basic_fires: got %0d want 4", fx_log.size() - bf); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (bf + i >= fx_log.size()) begin n_fail++; $display("FAIL basic_pair%0d: missing want %0d/%0d", i, i + 1, 101 + i); end
      else if (fx_log[bf+i] !== SW'(i + 1) || fu_log[bf+i] !== SW'(101 + i)) begin
        n_fail++; $display("FAIL basic_pair%0d: got %0d/%0d want %0d/%0d", i, fx_log[bf+i], fu_log[bf+i], i + 1, 101 + i); end
    end
    n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL basic_done: got %0d pulses want 1", done_cnt - bd); end
    n_checks++; if (busy_cnt - bb !== 5) begin n_fail++; $display("FAIL basic_busy: got %0d cycles want 5", busy_cnt - bb); end
    n_checks++; if (acc_x_cnt - bax !== 4 || acc_u_cnt - bau !== 4) begin
      n_fail++; $display("FAIL basic_accepts: got %0d/%0d want 4/4", acc_x_cnt - bax, acc_u_cnt - bau); end
    n_checks++; if (unstable_cnt - bun !== 0) begin n_fail++; $display("FAIL basic_stable: got %0d want 0", unstable_cnt - bun); end
  endtask

  task automatic test_un_sparse();
    int cyc; bit to;
    int bf = fx_log.size(), bd = done_cnt, bs = xstall_cnt, bun = unstable_cnt;
    drive_run(8, 3, 0, 200, 300, 100, 0, -1, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL sparse_timeout: got %b want 0", to); end
    n_checks++; if (fx_log.size() - bf !== 8) begin n_fail++; $display("FAIL sparse_fires: got %0d want 8", fx_log.size() - bf); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (bf + i >= fx_log.size()) begin n_fail++; $display("FAIL sparse_pair%0d: missing want %0d/%0d", i, 201 + i, 301 + i); end
      else if (fx_log[bf+i] !== SW'(201 + i) || fu_log[bf+i] !== SW'(301 + i)) begin
        n_fail++; $display("FAIL sparse_pair%0d: got %0d/%0d want %0d/%0d", i, fx_log[bf+i], fu_log[bf+i], 201 + i, 301 + i); end
    end
    n_checks++; if (xstall_cnt - bs <= 0) begin n_fail++; $display("FAIL sparse_xfull_stall: got %0d stall cycles want >0", xstall_cnt - bs); end
    n_checks++; if (unstable_cnt - bun !== 0) begin n_fail++; $display("FAIL sparse_stable: got %0d want 0", unstable_cnt - bun); end
    n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL sparse_done: got %0d pulses want 1", done_cnt - bd); end
  endtask

  task automatic test_iready_toggle();
    int cyc; bit to;
    int bf = fx_log.size(), bh = hold_cnt, bun = unstable_cnt;
    drive_run(6, 1, 1, 400, 500, 100, 0, -1, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL toggle_timeout: got %b want 0", to); end
    n_checks++; if (fx_log.size() - bf !== 6) begin n_fail++; $display("FAIL toggle_fires: got %0d want 6", fx_log.size() - bf); end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (bf + i >= fx_log.size()) begin n_fail++; $display("FAIL toggle_pair%0d: missing want %0d/%0d", i, 401 + i, 501 + i); end
      else if (fx_log[bf+i] !== SW'(401 + i) || fu_log[bf+i] !== SW'(501 + i)) begin
        n_fail++; $display("FAIL toggle_pair%0d: got %0d/%0d want %0d/%0d", i, fx_log[bf+i], fu_log[bf+i], 401 + i, 501 + i); end
    end
    n_checks++; if (hold_cnt - bh <= 0) begin n_fail++; $display("FAIL toggle_holds: got %0d hold cycles want >0", hold_cnt - bh); end
    n_checks++; if (unstable_cnt - bun !== 0) begin n_fail++; $display("FAIL toggle_stable: got %0d want 0", unstable_cnt - bun); end
  endtask

  task automatic test_zero_words();
    int cyc; bit to;
    int bf = fx_log.size(), bd = done_cnt, bb = busy_cnt, bxr = xrdy_cnt, bur = urdy_cnt, bi = ival_cnt;
    drive_run(0, 1, 0, 0, 0, 20, 0, -1, cyc, to);
    n_checks++; if (cyc !== 0) begin n_fail++; $display("FAIL zero_done_latency: got %0d extra cycles want 0", cyc); end
    n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL zero_done: got %0d pulses want 1", done_cnt - bd); end
    n_checks++; if (xrdy_cnt - bxr !== 0 || urdy_cnt - bur !== 0) begin
      n_fail++; $display("FAIL zero_mem_ready: got %0d/%0d want 0/0", xrdy_cnt - bxr, urdy_cnt - bur); end
    n_checks++; if (ival_cnt - bi !== 0 || fx_log.size() - bf !== 0) begin
      n_fail++; $display("FAIL zero_ivalid: got %0d valid cycles, %0d fires want 0/0", ival_cnt - bi, fx_log.size() - bf); end
    n_checks++; if (busy_cnt - bb !== 0) begin n_fail++; $display("FAIL zero_busy: got %0d want 0", busy_cnt - bb); end
  endtask

  task automatic test_reset_mid_run();
    int cyc; bit to;
    int bf = fx_log.size();
    int bd;
    drive_run(10, 1, 0, 600, 700, 60, 3, -1, cyc, to);
    n_checks++; if (fx_log.size() - bf !== 3) begin n_fail++; $display("FAIL rstmid_fires_before: got %0d want 3", fx_log.size() - bf); end
    n_checks++; if (ivalid_x_s0 !== 1'b1) begin n_fail++; $display("FAIL rstmid_prefill: got ivalid_x %b want 1", ivalid_x_s0); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ivalid_x_s0 !== 1'b0 || ivalid_un_s0 !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ivalid: got %b%b want 00", ivalid_x_s0, ivalid_un_s0); end
    n_checks++; if (x_s0 !== '0 || un_s0 !== '0) begin
      n_fail++; $display("FAIL rstmid_data: got %0h/%0h want 0/0", x_s0, un_s0); end
    n_checks++; if (busy !== 1'b0 || mem_x_ready !== 1'b0 || mem_un_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ctrl: got busy %b rdy %b%b want 0 00", busy, mem_x_ready, mem_un_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bf = fx_log.size();
    bd = done_cnt;
    drive_run(2, 1, 0, 800, 900, 40, 0, -1, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL rstmid_timeout: got %b want 0", to); end
    n_checks++; if (fx_log.size() - bf !== 2) begin n_fail++; $display("FAIL rstmid_fires_after: got %0d want 2", fx_log.size() - bf); end
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (bf + i >= fx_log.size()) begin n_fail++; $display("FAIL rstmid_pair%0d: missing want %0d/%0d", i, 801 + i, 901 + i); end
      else if (fx_log[bf+i] !== SW'(801 + i) || fu_log[bf+i] !== SW'(901 + i)) begin
        n_fail++; $display("FAIL rstmid_pair%0d: got %0d/%0d want %0d/%0d", i, fx_log[bf+i], fu_log[bf+i], 801 + i, 901 + i); end
    end
    n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL rstmid_done: got %0d pulses want 1", done_cnt - bd); end
  endtask

  task automatic test_start_while_busy();
    int cyc; bit to;
    int bf = fx_log.size(), bd = done_cnt, bb = busy_cnt, bax = acc_x_cnt;
    drive_run(5, 1, 0, 1000, 1100, 60, 0, 2, cyc, to);
    n_checks++; if (to !== 1'b0) begin n_fail++; $display("FAIL busystart_timeout: got %b want 0", to); end
    n_checks++; if (fx_log.size() - bf !== 5) begin n_fail++; $display("FAIL busystart_fires: got %0d want 5", fx_log.size() - bf); end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bf + i >= fx_log.size()) begin n_fail++; $display("FAIL busystart_pair%0d: missing want %0d/%0d", i, 1001 + i, 1101 + i); end
      else if (fx_log[bf+i] !== SW'(1001 + i) || fu_log[bf+i] !== SW'(1101 + i)) begin
        n_fail++; $display("FAIL busystart_pair%0d: got %0d/%0d want %0d/%0d", i, fx_log[bf+i], fu_log[bf+i], 1001 + i, 1101 + i); end
    end
    n_checks++; if (acc_x_cnt - bax !== 5) begin n_fail++; $display("FAIL busystart_accepts: got %0d want 5", acc_x_cnt - bax); end
    n_checks++; if (busy_cnt - bb !== 6) begin n_fail++; $display("FAIL busystart_busy: got %0d cycles want 6", busy_cnt - bb); end
    n_checks++; if (done_cnt - bd !== 1) begin n_fail++; $display("FAIL busystart_done: got %0d pulses want 1", done_cnt - bd); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busystart_idle_after: got busy %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_un_sparse();
    test_iready_toggle();
    test_zero_words();
    test_reset_mid_run();
    test_start_while_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
